pheap_ctl: RTL

//  Request front-end and issue scheduler for the pipelined heap. Accepts

---
 rtl/pheap_ctl.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/pheap_ctl.sv
// ---------------------------------------------------------------------------
// pheap_ctl : request front-end and issue scheduler for a pipelined heap.
//
// Accepts client enqueue / dequeue / replace requests, tracks occupancy and
// launches one opcode at a time into level 1 of the heap pipeline. Starts
// are spaced so that level 1 is back in its read phase before the next
// start. Dequeued or replaced-out key/values reach the client a fixed three
// cycles after acceptance.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        asynchronous reset, active low (0 = reset)
//   enq, deq   client request; both together = replace (ENQ_DEQ)
//   kv_in      key/value operand for enq / replace
//   ready      request is accepted this cycle if (enq|deq)&ready
//   out_valid  one-cycle pulse, kv_out carries a new result
//   kv_out     last dequeued / replaced-out key/value (held)
//   drop       one-cycle pulse, the accepted request was illegal
//   full       count == CAPACITY
//   empty      count == 0
//   count      current occupancy
//   start1     start strobe to level 1
//   op1, in1   opcode / operand to level 1, valid while start1 is high
//   out1       level-1 top value, valid in its SET_OUT cycle
// ---------------------------------------------------------------------------
module pheap_ctl #(
    parameter int LEVELS    = 3,
    parameter int ISSUE_GAP = 2,
    parameter int KEY_W     = 8,
    parameter int VAL_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq,
    input  logic                     deq,
    input  logic [KEY_W+VAL_W-1:0]   kv_in,
    output logic                     ready,
    output logic                     out_valid,
    output logic [KEY_W+VAL_W-1:0]   kv_out,
    output logic                     drop,
    output logic                     full,
    output logic                     empty,
    output logic [LEVELS-1:0]        count,
    output logic                     start1,
    output logic [1:0]               op1,
    output logic [KEY_W+VAL_W-1:0]   in1,
    input  logic [KEY_W+VAL_W-1:0]   out1
);

    localparam int KV_W  = KEY_W + VAL_W;
    // GAP holds ISSUE_GAP-1 cycles; the counter only has to reach that value.
    localparam int GAP_W = (ISSUE_GAP > 2) ? $clog2(ISSUE_GAP) : 1;

    localparam logic [KV_W-1:0]   KV_EMPTY   = {KV_W{1'b0}};
    localparam logic [LEVELS-1:0] CAPACITY   = {LEVELS{1'b1}};
    localparam logic [LEVELS-1:0] CNT_ZERO   = {LEVELS{1'b0}};
    localparam logic [1:0]        OP_ENQ     = 2'd0;
    localparam logic [1:0]        OP_DEQ     = 2'd1;
    localparam logic [1:0]        OP_ENQ_DEQ = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [LEVELS-1:0]  count_q, count_d;
    logic               start1_q, start1_d;
    logic [1:0]         op1_q, op1_d;
    logic [KV_W-1:0]    in1_q, in1_d;
    logic               drop_q, drop_d;
    // Result pipeline: stage a = issue cycle, stage b = level-1 SET_OUT cycle.
    logic               res_a_q, res_a_d, byp_a_q, byp_a_d;
    logic [KV_W-1:0]    kv_a_q, kv_a_d;
    logic               res_b_q, res_b_d, byp_b_q, byp_b_d;
    logic [KV_W-1:0]    kv_b_q, kv_b_d;
    logic               out_valid_q, out_valid_d;
    logic [KV_W-1:0]    kv_out_q, kv_out_d;

    logic               accept_s, illegal_s, bypass_s, issue_s, result_s;
    logic               enq_only_s, deq_only_s, both_s;
    logic [1:0]         op_s;

    // Request decode and legality against the occupancy at the accept edge.
    always_comb begin
        enq_only_s = enq & ~deq;
        deq_only_s = deq & ~enq;
        both_s     = enq & deq;
        accept_s   = (enq | deq) & (state_q == S_IDLE);
        illegal_s  = accept_s & ((enq_only_s & full) | (deq_only_s & empty));
        // Replace on an empty heap never touches level 1: the operand is the answer.
        bypass_s   = accept_s & both_s & empty;
        issue_s    = accept_s & ~illegal_s & ~bypass_s;
        result_s   = accept_s & deq & ~illegal_s;
        if (both_s) begin
            op_s = OP_ENQ_DEQ;
        end else if (deq_only_s) begin
            op_s = OP_DEQ;
        end else begin
            op_s = OP_ENQ;
        end
    end

    // Issue FSM next-state: one start, then ISSUE_GAP-1 quiet cycles.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: begin
                if (issue_s) begin
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_d = S_GAP;
                gap_d   = GAP_W'(ISSUE_GAP - 1);
            end
            S_GAP: begin
                if (gap_q <= GAP_W'(1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                gap_d   = {GAP_W{1'b0}};
            end
        endcase
    end

    // FSM outputs: requests are only taken while idle.
    always_comb begin
        ready = (state_q == S_IDLE);
    end

    // Datapath next values: occupancy, level-1 launch and result pipeline.
    always_comb begin
        count_d = count_q;
        if (issue_s && enq_only_s) begin
            count_d = count_q + LEVELS'(1);
        end else if (issue_s && deq_only_s) begin
            count_d = count_q - LEVELS'(1);
        end else begin
            count_d = count_q;
        end

        start1_d = issue_s;
        drop_d   = illegal_s;
        if (issue_s) begin
            op1_d = op_s;
            in1_d = kv_in;
        end else begin
            op1_d = op1_q;
            in1_d = in1_q;
        end

        res_a_d = result_s;
        byp_a_d = bypass_s;
        if (accept_s) begin
            kv_a_d = kv_in;
        end else begin
            kv_a_d = kv_a_q;
        end

        res_b_d = res_a_q;
        byp_b_d = byp_a_q;
        kv_b_d  = kv_a_q;

        out_valid_d = res_b_q;
        if (res_b_q && byp_b_q) begin
            kv_out_d = kv_b_q;
        end else if (res_b_q) begin
            kv_out_d = out1;
        end else begin
            kv_out_d = kv_out_q;
        end
    end

    // State register and all output flops; reset drops any result in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            gap_q       <= {GAP_W{1'b0}};
            count_q     <= CNT_ZERO;
            start1_q    <= 1'b0;
            op1_q       <= OP_ENQ;
            in1_q       <= KV_EMPTY;
            drop_q      <= 1'b0;
            res_a_q     <= 1'b0;
            byp_a_q     <= 1'b0;
            kv_a_q      <= KV_EMPTY;
            res_b_q     <= 1'b0;
            byp_b_q     <= 1'b0;
            kv_b_q      <= KV_EMPTY;
            out_valid_q <= 1'b0;
            kv_out_q    <= KV_EMPTY;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            count_q     <= count_d;
            start1_q    <= start1_d;
            op1_q       <= op1_d;
            in1_q       <= in1_d;
            drop_q      <= drop_d;
            res_a_q     <= res_a_d;
            byp_a_q     <= byp_a_d;
            kv_a_q      <= kv_a_d;
            res_b_q     <= res_b_d;
            byp_b_q     <= byp_b_d;
            kv_b_q      <= kv_b_d;
            out_valid_q <= out_valid_d;
            kv_out_q    <= kv_out_d;
        end
    end

    // Output wiring; full/empty decode directly from occupancy.
    always_comb begin
        count     = count_q;
        full      = (count_q == CAPACITY);
        empty     = (count_q == CNT_ZERO);
        start1    = start1_q;
        op1       = op1_q;
        in1       = in1_q;
        drop      = drop_q;
        out_valid = out_valid_q;
        kv_out    = kv_out_q;
    end

endmodule
